// File: rtl/core_bus_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone classic arbiter.
package core_bus_arb_pkg;

  // Arbiter FSM: idle or owned by one of the two masters
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  // Master index: 0 = instruction fetch, 1 = data
  typedef logic master_idx_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Bundle of both master ports, the bus-side port and the debug grant.
// slave  : arbiter view
// master : environment view (masters + bus target)
interface core_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic [DATA_WIDTH-1:0] m0_data_i, m0_data_o;
  logic                  m0_ack_o, m0_err_o;

  logic                  m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic [DATA_WIDTH-1:0] m1_data_i, m1_data_o;
  logic                  m1_ack_o, m1_err_o;

  logic                  core_cyc_o, core_stb_o, core_we_o;
  logic [ADDR_WIDTH-1:0] core_addr_o;
  logic [DATA_WIDTH-1:0] core_data_o, core_data_i;
  logic                  core_ack_i;

  logic [1:0]            grant_o;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i,
    output m0_data_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
    output m1_data_o, m1_ack_o, m1_err_o,
    output core_cyc_o, core_stb_o, core_we_o, core_addr_o, core_data_o,
    input  core_data_i, core_ack_i,
    output grant_o
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i,
    input  m0_data_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
    input  m1_data_o, m1_ack_o, m1_err_o,
    input  core_cyc_o, core_stb_o, core_we_o, core_addr_o, core_data_o,
    output core_data_i, core_ack_i,
    input  grant_o
  );
endinterface

// File: rtl/core_bus_arb_watchdog.sv
// Stall watchdog: counts enabled cycles, saturates at TIMEOUT_CYCLES and
// flags expire while the count sits at the limit. Clear has priority.
module core_bus_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Stall counter, held at LIMIT until cleared
  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable && count != LIMIT)
      count <= count + 1'b1;
  end

  assign expire = (count == LIMIT);
endmodule

// File: rtl/core_bus_arbiter.sv
// Two-master Wishbone classic arbiter, round robin, one idle cycle between
// owners. Optional stall watchdog under CORE_BUS_ARB_TIMEOUT_EN.
module core_bus_arbiter
  import core_bus_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic               clk,
  input logic               rst,
  core_bus_arbiter_if.slave bus
);
  arb_state_t  state;
  master_idx_t rr_prefer;   // master that wins the next tie
  logic [1:0]  grant_q;
  logic        expire;

  logic                  cyc, stb, we, ack0, ack1, err0, err1;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack_ok;

  // Ack from a cycle being killed (timeout or reset) is dropped
  assign ack_ok = bus.core_ack_i && !expire && !rst;

`ifdef CORE_BUS_ARB_TIMEOUT_EN
  logic wd_enable, wd_clear;

  assign wd_enable = ((state == GRANT0 && bus.m0_stb_i) ||
                      (state == GRANT1 && bus.m1_stb_i)) && !bus.core_ack_i;
  assign wd_clear  = bus.core_ack_i || (state == IDLE) || expire;

  core_bus_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .enable (wd_enable),
    .clear  (wd_clear),
    .expire (expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  // Arbitration FSM with registered grant and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_prefer <= 1'b0;
      grant_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_cyc_i && (!bus.m1_cyc_i || rr_prefer == 1'b0)) begin
            state     <= GRANT0;
            grant_q   <= 2'b01;
            rr_prefer <= 1'b1;
          end else if (bus.m1_cyc_i) begin
            state     <= GRANT1;
            grant_q   <= 2'b10;
            rr_prefer <= 1'b0;
          end
        end
        GRANT0: begin
          if (!bus.m0_cyc_i || expire) begin
            state   <= IDLE;
            grant_q <= 2'b00;
          end
        end
        GRANT1: begin
          if (!bus.m1_cyc_i || expire) begin
            state   <= IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  // Bus mux from the owner; cyc/stb are killed in the timeout cycle
  always_comb begin
    cyc   = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    ack0  = 1'b0;
    ack1  = 1'b0;
    err0  = 1'b0;
    err1  = 1'b0;
    case (state)
      GRANT0: begin
        cyc   = bus.m0_cyc_i && !expire;
        stb   = bus.m0_stb_i && !expire;
        we    = bus.m0_we_i;
        addr  = bus.m0_addr_i;
        wdata = bus.m0_data_i;
        ack0  = ack_ok;
        err0  = expire && !rst;
      end
      GRANT1: begin
        cyc   = bus.m1_cyc_i && !expire;
        stb   = bus.m1_stb_i && !expire;
        we    = bus.m1_we_i;
        addr  = bus.m1_addr_i;
        wdata = bus.m1_data_i;
        ack1  = ack_ok;
        err1  = expire && !rst;
      end
      default: ;
    endcase
  end

  assign bus.core_cyc_o  = cyc;
  assign bus.core_stb_o  = stb;
  assign bus.core_we_o   = we;
  assign bus.core_addr_o = addr;
  assign bus.core_data_o = wdata;
  assign bus.m0_ack_o    = ack0;
  assign bus.m1_ack_o    = ack1;
  assign bus.m0_err_o    = err0;
  assign bus.m1_err_o    = err1;
  assign bus.m0_data_o   = bus.core_data_i;
  assign bus.m1_data_o   = bus.core_data_i;
  assign bus.grant_o     = grant_q;
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter (TIMEOUT_CYCLES = 8). The stall
// scenario checks the watchdog when CORE_BUS_ARB_TIMEOUT_EN is defined
// and a held grant otherwise.
module tb_core_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  core_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  core_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 units later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_masters();
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0;
    bus.m0_addr_i = '0; bus.m0_data_i = '0;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
    bus.m1_addr_i = '0; bus.m1_data_i = '0;
    bus.core_ack_i = 0; bus.core_data_i = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    idle_masters();
    tick(); tick();
    #1;
    chk("rst_grant", bus.grant_o, 2'b00);
    chk("rst_cyc", bus.core_cyc_o, 0);
    chk("rst_ack", {bus.m0_ack_o, bus.m1_ack_o}, 2'b00);
    chk("rst_err", {bus.m0_err_o, bus.m1_err_o}, 2'b00);
    rst = 0;
    tick();

    // m0 read of 0x100, ack in the third cycle
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_addr_i = 32'h100;
    #1;
    chk("rd_latency_grant", bus.grant_o, 2'b00);
    chk("rd_latency_cyc", bus.core_cyc_o, 0);
    tick(); #1;
    chk("rd_grant", bus.grant_o, 2'b01);
    chk("rd_addr", bus.core_addr_o, 32'h100);
    chk("rd_noack", bus.m0_ack_o, 0);
    tick();
    bus.core_data_i = 32'hDEADBEEF; bus.core_ack_i = 1;
    #1;
    chk("rd_data", bus.m0_data_o, 32'hDEADBEEF);
    chk("rd_ack0", bus.m0_ack_o, 1);
    chk("rd_ack1", bus.m1_ack_o, 0);
    chk("rd_grant2", bus.grant_o, 2'b01);
    tick();
    idle_masters();
    tick(); #1;
    chk("rd_idle", bus.grant_o, 2'b00);

    // simultaneous request after reset: m0 first, then m1
    do_reset();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_addr_i = 32'h10;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_addr_i = 32'h20;
    tick(); #1;
    chk("rr_first", bus.grant_o, 2'b01);
    chk("rr_addr0", bus.core_addr_o, 32'h10);
    bus.core_ack_i = 1;
    #1;
    chk("rr_ack0", {bus.m1_ack_o, bus.m0_ack_o}, 2'b01);
    tick();
    bus.core_ack_i = 0; bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    tick(); #1;
    chk("rr_gap_grant", bus.grant_o, 2'b00);
    chk("rr_gap_cyc", bus.core_cyc_o, 0);
    tick(); #1;
    chk("rr_second", bus.grant_o, 2'b10);
    chk("rr_addr1", bus.core_addr_o, 32'h20);
    bus.core_ack_i = 1;
    #1;
    chk("rr_ack1", {bus.m1_ack_o, bus.m0_ack_o}, 2'b10);
    tick();
    idle_masters();
    tick();

    // m1 write waits while m0 holds the bus for 4 beats
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_addr_i = 32'hA00;
    tick();
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1;
    bus.m1_addr_i = 32'h2000; bus.m1_data_i = 32'h55AA;
    for (int i = 0; i < 4; i++) begin
      bus.m0_addr_i = 32'hA00 + 32'(4 * i);
      bus.core_ack_i = 1;
      #1;
      chk("hold_addr", bus.core_addr_o, 32'hA00 + 32'(4 * i));
      chk("hold_we", bus.core_we_o, 0);
      chk("hold_acks", {bus.m1_ack_o, bus.m0_ack_o}, 2'b01);
      tick();
    end
    bus.core_ack_i = 0; bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    #1;
    chk("hold_drop_cyc", bus.core_cyc_o, 0);
    chk("hold_drop_ack1", bus.m1_ack_o, 0);
    tick(); #1;
    chk("hold_idle", bus.grant_o, 2'b00);
    chk("hold_idle_ack1", bus.m1_ack_o, 0);
    tick(); #1;
    chk("wr_grant", bus.grant_o, 2'b10);
    chk("wr_addr", bus.core_addr_o, 32'h2000);
    chk("wr_data", bus.core_data_o, 32'h55AA);
    chk("wr_we", bus.core_we_o, 1);
    chk("wr_noack", bus.m1_ack_o, 0);
    bus.core_ack_i = 1;
    #1;
    chk("wr_ack", {bus.m1_ack_o, bus.m0_ack_o}, 2'b10);
    tick();
    idle_masters();
    tick();

    // reset during a GRANT1 read aborts it
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_addr_i = 32'h300;
    tick(); #1;
    chk("ab_grant", bus.grant_o, 2'b10);
    chk("ab_ack_pre", bus.m1_ack_o, 0);
    rst = 1;
    tick(); #1;
    chk("ab_cyc", bus.core_cyc_o, 0);
    chk("ab_grant0", bus.grant_o, 2'b00);
    chk("ab_ack_rst", bus.m1_ack_o, 0);
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
    rst = 0;
    bus.core_ack_i = 1;
    #1;
    chk("ab_ack_post", bus.m1_ack_o, 0);
    tick();
    idle_masters();
    do_reset();

    // m0 stall with no ack
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_addr_i = 32'h400;
    tick();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("stall_grant", bus.grant_o, 2'b01);
      chk("stall_err", bus.m0_err_o, 0);
      chk("stall_cyc", bus.core_cyc_o, 1);
      tick();
    end
`ifdef CORE_BUS_ARB_TIMEOUT_EN
    #1;
    chk("to_err", {bus.m1_err_o, bus.m0_err_o}, 2'b01);
    chk("to_cyc", bus.core_cyc_o, 0);
    chk("to_stb", bus.core_stb_o, 0);
    tick(); #1;
    chk("to_err_pulse", bus.m0_err_o, 0);
    chk("to_idle", bus.grant_o, 2'b00);
    chk("to_idle_cyc", bus.core_cyc_o, 0);
`else
    for (int k = 0; k < 92; k++) begin
      #1;
      chk("nto_grant", bus.grant_o, 2'b01);
      chk("nto_err", {bus.m1_err_o, bus.m0_err_o}, 2'b00);
      tick();
    end
`endif
    idle_masters();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
